// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with fetch queue and redirect handling
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misalign_err
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [63:0]   fq [FQ_DEPTH];
  logic          halted;
  logic          pop;
  logic          push;
  logic          fq_full;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign fq_full      = (count == CW'(FQ_DEPTH));
  assign imem_addr    = fetch_pc;
  assign out_valid    = (count != '0) && !redirect_valid;
  assign pop          = out_valid && out_ready;
  assign push         = fetch_en && !redirect_valid && !halted && (!fq_full || pop);
  assign {out_pc, out_instr} = fq[head];

`ifdef FETCH_MISALIGN_TRAP_EN
  // The error flag doubles as the fetch halt; only a redirect can change either.
  logic trap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (redirect_valid) begin
      trap_q <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign halted       = trap_q;
  assign misalign_err = trap_q;
`else
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fq[tail] <= {fetch_pc, imem_rdata};
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed table-driven bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a < 32'd16) begin
      case (a[3:2])
        2'd0:    return 32'h0050_0093;
        2'd1:    return 32'h00A0_0113;
        2'd2:    return 32'h0020_81B3;
        default: return 32'h0000_0013;
      endcase
    end
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [31:0] exp_pc);
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".pc"}, out_pc, exp_pc);
    check({name, ".instr"}, out_instr, mem_f(exp_pc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          fe;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    bit          emis;
  } vec_t;

  vec_t vecs [27];

  initial begin
    vecs[0]  = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h0,   0};
    vecs[1]  = '{1, 1, 0, 32'h0,   1, 32'h0,   32'h4,   0};
    vecs[2]  = '{1, 1, 0, 32'h0,   1, 32'h4,   32'h8,   0};
    vecs[3]  = '{1, 1, 0, 32'h0,   1, 32'h8,   32'hC,   0};
    vecs[4]  = '{1, 1, 0, 32'h0,   1, 32'hC,   32'h10,  0};
    vecs[5]  = '{0, 1, 0, 32'h0,   1, 32'h10,  32'h14,  0};
    vecs[6]  = '{0, 1, 0, 32'h0,   0, 32'h0,   32'h14,  0};
    vecs[7]  = '{1, 0, 0, 32'h0,   0, 32'h0,   32'h14,  0};
    vecs[8]  = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h18,  0};
    vecs[9]  = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h1C,  0};
    vecs[10] = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h1C,  0};
    vecs[11] = '{1, 1, 0, 32'h0,   1, 32'h14,  32'h1C,  0};
    vecs[12] = '{1, 1, 0, 32'h0,   1, 32'h18,  32'h20,  0};
    vecs[13] = '{1, 1, 1, 32'h100, 0, 32'h0,   32'h24,  0};
    vecs[14] = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h100, 0};
    vecs[15] = '{1, 1, 0, 32'h0,   1, 32'h100, 32'h104, 0};
    vecs[16] = '{1, 1, 1, 32'h22,  0, 32'h0,   32'h108, 0};
    vecs[17] = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h20,  TRAP};
    vecs[18] = '{1, 1, 0, 32'h0,   !TRAP, 32'h20, TRAP ? 32'h20 : 32'h24, TRAP};
    vecs[19] = '{1, 1, 1, 32'h40,  0, 32'h0,   TRAP ? 32'h20 : 32'h28, TRAP};
    vecs[20] = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h40,  0};
    vecs[21] = '{1, 1, 0, 32'h0,   1, 32'h40,  32'h44,  0};
    vecs[22] = '{1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h48, 0};
    vecs[23] = '{1, 1, 0, 32'h0,   0, 32'h0,   32'hFFFF_FFF8, 0};
    vecs[24] = '{1, 1, 0, 32'h0,   1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0};
    vecs[25] = '{1, 1, 0, 32'h0,   1, 32'hFFFF_FFFC, 32'h0, 0};
    vecs[26] = '{1, 1, 0, 32'h0,   1, 32'h0,   32'h4,   0};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (i != 0) @(negedge clk);
      fetch_en = vecs[i].fe; out_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      #1;
      check($sformatf("v%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d.addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d.mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].emis});
      if (vecs[i].ev) begin
        check($sformatf("v%0d.pc", i), out_pc, vecs[i].epc);
        check($sformatf("v%0d.instr", i), out_instr, mem_f(vecs[i].epc));
      end
    end

    // backpressure: 5 stalled cycles from reset, then drain 0,4,8 back to back
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("bp.addr_hold", imem_addr, 32'h8);
    check_head("bp.stall_head", 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_head($sformatf("bp.drain%0d", k), 32'(k * 4));
      @(negedge clk);
    end

    // reset mid-operation with two entries queued
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_head("mr.pre", 32'h0);
    check("mr.pre_addr", imem_addr, 32'h8);
    #1;
    reset = 1'b1;
    #1;
    check("mr.valid_drop", {31'd0, out_valid}, 32'd0);
    check("mr.addr", imem_addr, 32'h0);
    check("mr.mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("mr.empty", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check_head("mr.first", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
